stream_mux4: RTL and testbench
==============================

# stream_mux4

Four-to-one streaming merge stage: the gather-side counterpart of the demultiplexer. It merges four valid/ready input channels into one output channel. Packets are arbitrated round-robin, and a granted channel holds the output until its last beat. Each output beat carries the index of its source channel, so a downstream demultiplexer can route responses back. The block sits between per-source producers and a single shared consumer, such as a memory or bus port.

## Interface
- WIDTH, 16, data bits per beat.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  in  4  per-channel beat valid; bit i = channel i.
- in_data  in  4*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_last  in  4  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  out  4  per-channel accept; at most one bit high per cycle.
- out_valid  out  1  registered output beat valid.
- out_data  out  WIDTH  registered output data.
- out_last  out  1  registered end-of-packet flag.
- out_sel  out  2  source channel index of the current output beat.
- out_ready  in  1  consumer accept.

## Operation
- Output stage: a single registered slot. The slot can load when it is free: free = !out_valid || out_ready.
- Transfer rules:
  - Input i transfers when in_valid[i] && in_ready[i].
  - Output transfers when out_valid && out_ready.
- Round-robin pointer ptr (2 bits):
  - Resets to 0.
  - Grant candidate is the first valid channel scanning ptr, ptr+1, ptr+2, ptr+3, mod 4.
- State machine, 2 states:
  - IDLE: if free and any in_valid, grant the candidate g.
    - in_ready[g]=1 combinationally; the beat loads into the slot; out_sel<=g.
    - If in_last[g]=1 on that beat: stay IDLE, ptr<=g+1 (mod 4, wraps 3->0).
    - Otherwise: go to LOCKED with lock_ch<=g.
  - LOCKED: only lock_ch is eligible. in_ready[lock_ch]=free; all other in_ready bits stay 0, even if those channels are valid.
    - Accepting a beat with in_last=1 returns the block to IDLE and sets ptr<=lock_ch+1.
    - If in_valid[lock_ch]=0, the block stays LOCKED and does not load; out_valid drops once the slot drains.
- Slot update:
  - On an input transfer: out_data, out_last, out_sel load and out_valid<=1.
  - Else on an output transfer: out_valid<=0; data/last/sel hold their values.
  - Otherwise all slot registers hold.
- in_ready is never high while !free. Input data is never dropped or duplicated.
- No in_valid bits set: no grant, ptr unchanged.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - ptr=0, state=IDLE, lock_ch=0.
  - in_ready=4'b0000 while reset is high, regardless of other inputs.
- Latency: 1 cycle. A beat accepted at edge k is visible on the outputs after edge k.
- Throughput: 1 beat/cycle with out_ready held high. Accept and drain in the same cycle are both allowed.
- Backpressure: with out_ready=0 and out_valid=1, in_ready=0 and the output holds stable.
- Boundary cases:
  - A single-beat packet (in_last on the first beat) never enters LOCKED.
  - Reset asserted mid-packet:
    - The block returns to IDLE, drops out_valid and clears ptr.
    - Partially sent packets are not resumed; upstream producers are reset together with this block.
- Fairness: among channels that continuously present packets, each is granted once per 4 packet grants.

## Test plan
- Reset: assert reset 2 cycles with all in_valid=4'b1111 -> in_ready=0, out_valid=0, out_sel=0 throughout; after release, the first grant goes to channel 0.
- Round-robin: all four channels valid with single-beat packets (in_data = 16'h00A0+i, in_last=1), out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, data 00A0..00A3.
- Packet lock: channel 2 sends a 3-beat packet (16'h1111, 16'h2222, 16'h3333, last on the third) while channel 0 stays valid -> outputs 1111, 2222, 3333 with out_sel=2, then channel 0; in_ready[0]=0 during the lock.
- Backpressure: single beat 16'hBEEF on channel 1, out_ready=0 for 3 cycles -> out_valid=1 and out_data=BEEF held, in_ready=0 throughout; one transfer when out_ready rises.
- Lock gap: channel 3 sends beat 1 (last=0), then drops valid for 2 cycles with channel 1 valid -> no grant to channel 1, out_valid=0 after drain; channel 3's final beat completes the packet, then channel 0 is granted if valid (ptr wrapped 3->0), else channel 1.
- Mid-packet reset: reset during LOCKED on channel 1 -> next cycle in IDLE with ptr=0 and out_valid=0; a new packet from channel 1 is arbitrated normally.

Source files
------------

// File: rtl/stream_mux4.sv
// Four-to-one valid/ready merge with round-robin packet arbitration.
// A granted channel owns the single output slot until its last beat.
module stream_mux4 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_last,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_lock;
    logic [1:0]       w_lock_nxt;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [1:0]       r_sel;

    logic             w_free;
    logic             w_found;
    logic [1:0]       w_cand;
    logic [1:0]       w_src;
    logic [3:0]       w_ready;
    logic             w_acc;
    logic [WIDTH-1:0] w_beat_data;
    logic             w_beat_last;

    assign w_free = !r_valid || out_ready;

    // Descending scan so the lowest offset from ptr wins.
    always_comb begin
        logic [1:0] w_idx;
        w_found = 1'b0;
        w_cand  = r_ptr;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (in_valid[w_idx]) begin
                w_found = 1'b1;
                w_cand  = w_idx;
            end
        end
    end

    always_comb begin
        w_ready     = 4'b0000;
        w_src       = r_lock;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        if (!reset) begin
            unique case (r_state)
                S_IDLE: begin
                    w_src = w_cand;
                    if (w_free && w_found)
                        w_ready[w_cand] = 1'b1;
                end
                S_LOCKED: begin
                    w_src = r_lock;
                    w_ready[r_lock] = w_free;
                end
            endcase
        end
        w_acc       = in_valid[w_src] && w_ready[w_src];
        w_beat_last = in_last[w_src];
        w_beat_data = in_data[w_src*WIDTH +: WIDTH];
        if (w_acc) begin
            if (w_beat_last) begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = w_src + 2'd1;
            end else begin
                w_state_nxt = S_LOCKED;
                w_lock_nxt  = w_src;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_lock  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_sel   <= 2'd0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_data  <= w_beat_data;
            r_last  <= w_beat_last;
            r_sel   <= w_src;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign out_sel   = r_sel;

endmodule

// File: tb/tb_stream_mux4.sv
// Self-checking bench for stream_mux4: directed scenarios plus a
// randomized round-robin stream checked against a packet-order model.
module tb_stream_mux4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic [1:0]  out_sel;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    stream_mux4 #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic drive_lane(input int c, input logic v,
                              input logic [15:0] d, input logic l);
        in_valid[c]        = v;
        in_data[c*16 +: 16] = d;
        in_last[c]         = l;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 4'b0000;
        in_last   = 4'b0000;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            drive_lane(i, 1'b1, 16'h00A0 + 16'(i), 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
            end
            n_checks++;
            if ({out_valid, out_sel, out_last, out_data} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_outputs v=%b sel=%0d last=%b data=%h exp all zero",
                         out_valid, out_sel, out_last, out_data);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant got=%b exp=0001", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 16'h00A0}) begin
            n_fail++;
            $display("FAIL reset_first_beat v=%b sel=%0d data=%h exp v=1 sel=0 data=00a0",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 4; i++)
            drive_lane(i, 1'b1, 16'h00A0 + 16'(i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_sel, out_last, out_data} !==
                {1'b1, 2'(k % 4), 1'b1, 16'h00A0 + 16'(k % 4)}) begin
                n_fail++;
                $display("FAIL rr_beat%0d v=%b sel=%0d data=%h exp sel=%0d data=%h",
                         k, out_valid, out_sel, out_data, k % 4, 16'h00A0 + 16'(k % 4));
            end
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_packet_lock();
        logic [15:0] exp_d [4];
        logic [1:0]  exp_s [4];
        logic [3:0]  exp_r [4];
        exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h0C0C};
        exp_s = '{2'd2, 2'd2, 2'd2, 2'd0};
        exp_r = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                n_checks++;
                if ({out_valid, out_sel, out_data} !== {1'b1, exp_s[k-1], exp_d[k-1]}) begin
                    n_fail++;
                    $display("FAIL lock_beat%0d sel=%0d data=%h exp sel=%0d data=%h",
                             k - 1, out_sel, out_data, exp_s[k-1], exp_d[k-1]);
                end
            end
            if (k < 3) drive_lane(2, 1'b1, exp_d[k], k == 2);
            else       drive_lane(2, 1'b0, 16'h0, 1'b0);
            if (k > 0) drive_lane(0, 1'b1, 16'h0C0C, 1'b1);
            #1;
            n_checks++;
            if (in_ready !== exp_r[k]) begin
                n_fail++;
                $display("FAIL lock_ready%0d got=%b exp=%b", k, in_ready, exp_r[k]);
            end
        end
        @(negedge clk);
        in_valid = 4'b0000;
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 16'h0C0C}) begin
            n_fail++;
            $display("FAIL lock_after sel=%0d data=%h exp sel=0 data=0c0c", out_sel, out_data);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        drive_lane(1, 1'b1, 16'hBEEF, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_accept got=%b exp=0010", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_lane(1, 1'b1, 16'hCAFE, 1'b1);
            #1;
            n_checks++;
            if ({out_valid, out_data, in_ready} !== {1'b1, 16'hBEEF, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold%0d v=%b data=%h ready=%b exp v=1 data=beef ready=0000",
                         k, out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release got=%b exp=0010", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 16'hCAFE}) begin
            n_fail++;
            $display("FAIL bp_next v=%b data=%h exp v=1 data=cafe", out_valid, out_data);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain v=%b exp=0", out_valid);
        end
    endtask

    task automatic test_lock_gap();
        apply_reset();
        drive_lane(3, 1'b1, 16'h3001, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL gap_first got=%b exp=1000", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_sel, out_last, out_data} !== {1'b1, 2'd3, 1'b0, 16'h3001}) begin
            n_fail++;
            $display("FAIL gap_beat1 sel=%0d last=%b data=%h exp sel=3 last=0 data=3001",
                     out_sel, out_last, out_data);
        end
        drive_lane(3, 1'b0, 16'h0, 1'b0);
        drive_lane(1, 1'b1, 16'h1B1B, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ((in_ready & 4'b0111) !== 4'b0000) begin
                n_fail++;
                $display("FAIL gap_no_grant%0d got=%b exp=0xxx zero", k, in_ready);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_drained%0d v=%b exp=0", k, out_valid);
            end
        end
        drive_lane(3, 1'b1, 16'h3002, 1'b1);
        drive_lane(0, 1'b1, 16'h0A0A, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL gap_final_ready got=%b exp=1000", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_sel, out_last, out_data} !== {1'b1, 2'd3, 1'b1, 16'h3002}) begin
            n_fail++;
            $display("FAIL gap_beat2 sel=%0d last=%b data=%h exp sel=3 last=1 data=3002",
                     out_sel, out_last, out_data);
        end
        drive_lane(3, 1'b0, 16'h0, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL gap_wrap got=%b exp=0001", in_ready);
        end
        @(negedge clk);
        drive_lane(0, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if ({out_sel, out_data} !== {2'd0, 16'h0A0A}) begin
            n_fail++;
            $display("FAIL gap_ch0 sel=%0d data=%h exp sel=0 data=0a0a", out_sel, out_data);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 16'h1B1B}) begin
            n_fail++;
            $display("FAIL gap_ch1 sel=%0d data=%h exp sel=1 data=1b1b", out_sel, out_data);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        drive_lane(0, 1'b1, 16'h5000, 1'b1);
        @(negedge clk);
        drive_lane(0, 1'b0, 16'h0, 1'b0);
        drive_lane(1, 1'b1, 16'h5101, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({out_sel, out_last, out_data} !== {2'd1, 1'b0, 16'h5101}) begin
            n_fail++;
            $display("FAIL mr_locked sel=%0d data=%h exp sel=1 data=5101", out_sel, out_data);
        end
        reset = 1'b1;
        drive_lane(1, 1'b1, 16'h5102, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mr_ready_in_reset got=%b exp=0000", in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({out_valid, out_sel} !== 3'b000) begin
            n_fail++;
            $display("FAIL mr_cleared v=%b sel=%0d exp v=0 sel=0", out_valid, out_sel);
        end
        drive_lane(0, 1'b1, 16'h6000, 1'b1);
        drive_lane(1, 1'b1, 16'h6101, 1'b1);
        drive_lane(2, 1'b1, 16'h6200, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mr_ptr_cleared got=%b exp=0001", in_ready);
        end
        @(negedge clk);
        drive_lane(0, 1'b0, 16'h0, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL mr_ch1_grant got=%b exp=0010", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        n_checks++;
        if ({out_valid, out_sel, out_last, out_data} !== {1'b1, 2'd1, 1'b1, 16'h6101}) begin
            n_fail++;
            $display("FAIL mr_ch1_beat sel=%0d data=%h exp sel=1 data=6101", out_sel, out_data);
        end
        @(negedge clk);
    endtask

    // Every channel always has a packet pending, so the merged stream must
    // be whole packets taken from channels 0,1,2,3,0,... in turn.
    task automatic test_random_stream();
        logic [15:0] q_d [4][$];
        logic        q_l [4][$];
        logic [18:0] exp_q [$];
        logic [18:0] e;
        logic [15:0] d;
        int          len;
        int          cyc;
        apply_reset();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    d = 16'($urandom);
                    q_d[c].push_back(d);
                    q_l[c].push_back(b == len - 1);
                    exp_q.push_back({2'(c), b == len - 1, d});
                end
            end
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) begin
                if (q_d[c].size() > 0)
                    drive_lane(c, 1'b1, q_d[c][0], q_l[c][0]);
                else
                    drive_lane(c, 1'b0, 16'h0, 1'b0);
            end
            #1;
            n_checks++;
            if (!$onehot0(in_ready) || (in_ready != 4'b0000 && out_valid && !out_ready)) begin
                n_fail++;
                $display("FAIL rand_ready cyc=%0d ready=%b v=%b out_ready=%b",
                         cyc, in_ready, out_valid, out_ready);
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({out_sel, out_last, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL rand_beat cyc=%0d sel=%0d last=%b data=%h exp sel=%0d last=%b data=%h",
                             cyc, out_sel, out_last, out_data, e[18:17], e[16], e[15:0]);
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    void'(q_d[c].pop_front());
                    void'(q_l[c].pop_front());
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout remaining=%0d exp=0", exp_q.size());
        end
        @(negedge clk);
        in_valid  = 4'b0000;
        out_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 4'b0000;
        in_data   = '0;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_lock_gap();
        test_mid_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
